ps2_command_sender: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
//  It runs the inhibit/request-to-send sequence, shifts out data+parity+stop on device-generated clocks,

---
 rtl/ps2_command_sender_pkg.sv | 45 ++++
 rtl/ps2_command_sender_line_sync.sv | 47 ++++
 rtl/ps2_command_sender.sv | 170 +++++++++++++++++
 tb/tb_ps2_command_sender.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_command_sender_pkg.sv
// ============================================================================
// Module : ps2_command_sender_pkg
// Brief  : States, command bytes and default timing for the PS/2 command path
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ps2_command_sender_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INHIBIT    = 4'd1,
        ST_REQUEST    = 4'd2,
        ST_WAIT_FIRST = 4'd3,
        ST_SHIFT      = 4'd4,
        ST_WAIT_ACK   = 4'd5,
        ST_WAIT_IDLE  = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERR        = 4'd8
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_XFER_TIMEOUT   = 100000;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_command_sender_line_sync.sv
// ============================================================================
// Module : ps2_command_sender_line_sync
// Brief  : Two-flop synchronizer for PS/2 clock and data plus clock fall pulse
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_command_sender_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_prev;
    logic r_dat_s1;
    logic r_dat_s2;

    // Idle bus is high, so reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign clk_sync = r_clk_s2;
    assign dat_sync = r_dat_s2;
    assign clk_fall = r_clk_prev & ~r_clk_s2;

endmodule

`default_nettype wire

// File: rtl/ps2_command_sender.sv
// ============================================================================
// Module : ps2_command_sender
// Brief  : Host-to-device PS/2 transmitter: inhibit, request, shift, ack check
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ps2_command_sender
    import ps2_command_sender_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int TIMER_W = timer_width(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
    // REQUEST keeps the clock low for one more cycle, so INHIBIT ends one early
    // and the total clock-low time is exactly INHIBIT_CYCLES.
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [TIMER_W-1:0]   w_timer_inc;
    logic [3:0]           r_bitcnt;
    logic [3:0]           w_bitcnt_nxt;
    logic [9:0]           r_shift;
    logic [9:0]           w_shift_nxt;
    logic                 r_dat_low;
    logic                 w_dat_low_nxt;
    logic                 w_clk_low;
    logic                 w_clk_sync;
    logic                 w_dat_sync;
    logic                 w_clk_fall;

    ps2_command_sender_line_sync u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .clk_sync (w_clk_sync),
        .dat_sync (w_dat_sync),
        .clk_fall (w_clk_fall)
    );

    assign w_timer_inc = (&r_timer) ? r_timer : r_timer + TIMER_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = w_timer_inc;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_dat_low_nxt = r_dat_low;
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt   = '0;
                w_bitcnt_nxt  = 4'd0;
                w_dat_low_nxt = 1'b0;
                if (send) begin
                    // Frame shifts out LSB first: d0..d7, parity, stop.
                    w_shift_nxt = {1'b1, odd_parity(command), command};
                    w_state_nxt = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_timer >= INHIBIT_LAST) begin
                    w_dat_low_nxt = 1'b1;
                    w_state_nxt   = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_WAIT_FIRST;
            end
            ST_WAIT_FIRST: begin
                if (w_clk_fall) begin
                    w_dat_low_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b1, r_shift[9:1]};
                    w_bitcnt_nxt  = 4'd1;
                    w_timer_nxt   = '0;
                    w_state_nxt   = ST_SHIFT;
                end else if (r_timer >= START_LAST) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_SHIFT: begin
                if (r_timer >= XFER_LAST) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_fall) begin
                    w_dat_low_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b1, r_shift[9:1]};
                    w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd9) begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (r_timer >= XFER_LAST) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_fall) begin
                    w_bitcnt_nxt = 4'd11;
                    w_state_nxt  = w_dat_sync ? ST_ERR : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (r_timer >= XFER_LAST) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_sync && w_dat_sync) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE, ST_ERR: begin
                w_timer_nxt   = '0;
                w_bitcnt_nxt  = 4'd0;
                w_dat_low_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_timer_nxt   = '0;
                w_bitcnt_nxt  = 4'd0;
                w_dat_low_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
        if (w_state_nxt == ST_ERR) begin
            w_dat_low_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bitcnt  <= 4'd0;
            r_shift   <= '0;
            r_dat_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_dat_low <= w_dat_low_nxt;
        end
    end

    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERR);
    assign w_clk_low = (r_state == ST_INHIBIT) || (r_state == ST_REQUEST);

    assign PS2_CLK = w_clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = r_dat_low ? 1'b0 : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_ps2_command_sender.sv
// ============================================================================
// Module : tb_ps2_command_sender
// Brief  : Directed bench with a PS/2 device model and response scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_command_sender;
    import ps2_command_sender_pkg::*;

    localparam int INH = 1000;
    localparam int STO = 1500;
    localparam int XTO = 2000;
    localparam int H   = 40;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       send    = 1'b0;
    logic [7:0] command = 8'h00;
    logic       busy;
    logic       done;
    logic       error;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup pu_clk (ps2_clk);
    pullup pu_dat (ps2_dat);

    ps2_command_sender #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .send    (send),
        .command (command),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit    is_err;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   passed   = 0;
    int   total    = 0;
    int   resp_cyc = 0;
    int   resp_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Monitor: every done/error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (done || error)) begin
            resp_cyc = cyc;
            resp_cnt++;
            check("done_error_exclusive", done & error, 0);
            check("busy_low_on_response", busy, 0);
            check("response_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_is_error"}, error, e.is_err);
            end
        end
    end

    task automatic do_send(input logic [7:0] c);
        send    = 1'b1;
        command = c;
        @(negedge clk);
        send    = 1'b0;
        command = ~c;
        check("busy_after_accept", busy, 1);
    endtask

    // Device side: measure inhibit, then clock nfalls bits (11 = full frame + ack).
    task automatic dev_xfer(input int nfalls, input bit ack_low, output logic [9:0] frame,
                            output int low_cnt, output logic start_bit,
                            output int rel_cyc, output int fall_cyc);
        int t;
        t = 0;
        frame = '1; low_cnt = 0; start_bit = 1'b1; rel_cyc = 0; fall_cyc = 0;
        while (ps2_clk !== 1'b0 && t < 4 * INH) begin
            @(negedge clk);
            t++;
        end
        check("host_inhibit_seen", ps2_clk, 0);
        while (ps2_clk === 1'b0 && low_cnt < 4 * INH) begin
            @(negedge clk);
            low_cnt++;
        end
        rel_cyc   = cyc;
        start_bit = ps2_dat;
        if (nfalls > 0) begin
            repeat (10) @(negedge clk);
            fall_cyc = cyc;
            for (int i = 0; i < nfalls && i < 10; i++) begin
                dev_clk_low = 1'b1;
                repeat (H) @(negedge clk);
                frame[i]    = ps2_dat;
                dev_clk_low = 1'b0;
                repeat (H) @(negedge clk);
            end
            if (nfalls > 10) begin
                dev_dat_low = ack_low;
                repeat (H / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (H) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H / 2) @(negedge clk);
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while (busy && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("busy_released", busy, 0);
        repeat (3) @(negedge clk);
        check("clk_line_released", ps2_clk, 1);
        check("dat_line_released", ps2_dat, 1);
    endtask

    task automatic run_frame(input logic [7:0] c, input bit ack_low, input bit exp_err,
                             input logic exp_par, input string name);
        logic [9:0] fr;
        int         lc, rc, fc;
        logic       sb;
        exp_q.push_back('{exp_err, name});
        do_send(c);
        dev_xfer(11, ack_low, fr, lc, sb, rc, fc);
        wait_idle(XTO);
        check({name, "_inhibit_len"}, lc, INH);
        check({name, "_start_bit"}, sb, 0);
        check({name, "_data"}, fr[7:0], c);
        check({name, "_parity"}, fr[8], exp_par);
        check({name, "_stop"}, fr[9], 1);
    endtask

    initial begin
        logic [9:0] fr;
        int         lc, rc, fc;
        logic       sb;

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_clk_line", ps2_clk, 1);
        check("reset_dat_line", ps2_dat, 1);
        reset = 1'b0;
        @(negedge clk);

        run_frame(CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, "ed");
        run_frame(8'h01,        1'b1, 1'b0, 1'b0, "x01");
        run_frame(CMD_RESET,    1'b1, 1'b0, 1'b1, "ff");
        run_frame(CMD_SET_LEDS, 1'b0, 1'b1, 1'b1, "nack");

        exp_q.push_back('{1'b1, "start_to"});
        do_send(CMD_ENABLE);
        dev_xfer(0, 1'b0, fr, lc, sb, rc, fc);
        wait_idle(STO + 100);
        check("start_timeout_cycles", resp_cyc - rc, STO);

        exp_q.push_back('{1'b1, "xfer_to"});
        do_send(CMD_ENABLE);
        dev_xfer(5, 1'b0, fr, lc, sb, rc, fc);
        wait_idle(XTO + 100);
        check_range("xfer_timeout_cycles", resp_cyc - fc, XTO + 2, XTO + 4);

        // Abort after four bits; d3 of 8'hF4 is 0 so the data line is driven.
        do_send(CMD_ENABLE);
        dev_xfer(4, 1'b0, fr, lc, sb, rc, fc);
        check("pre_reset_dat_driven", ps2_dat, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_clk_line", ps2_clk, 1);
        check("abort_dat_line", ps2_dat, 1);
        reset = 1'b0;
        @(negedge clk);
        run_frame(CMD_ENABLE, 1'b1, 1'b0, 1'b0, "f4");

        fork
            run_frame(CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, "ignore");
            begin
                repeat (100) @(negedge clk);
                check("busy_when_resend", busy, 1);
                send    = 1'b1;
                command = 8'h00;
                @(negedge clk);
                send    = 1'b0;
            end
        join

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("response_count", resp_cnt, 8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

`default_nettype wire
